// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state, and arbiter grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache/RAM-side signal bundle of the memory arbiter; slave is the arbiter's view.
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      halt;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    logic      dlock;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      igrant;
    logic      dgrant;
    logic      arb_err;

    modport slave (
        input  halt, iREN, iaddr, dREN, dWEN, dlock, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               igrant, dgrant, arb_err
    );

    modport master (
        output halt, iREN, iaddr, dREN, dWEN, dlock, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               igrant, dgrant, arb_err
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between icache and dcache: dcache priority, dcache lock,
// and a starvation limit that forces an icache grant after STARVE_LIMIT dcache grants.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input logic                CLK,
    input logic                RST,
    cache_mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic d_req;
    logic i_ok;
    logic in_grant;
    logic done;

    function automatic arb_state_t pick(input logic [CNT_W-1:0] cnt,
                                        input logic dreq, input logic iok);
        if (iok && cnt == LIMIT) return ARB_I;
        if (dreq)                return ARB_D;
        if (iok)                 return ARB_I;
        return ARB_IDLE;
    endfunction

    always_comb begin
        d_req    = bus.dREN | bus.dWEN;
        i_ok     = bus.iREN & ~bus.halt;
        in_grant = (state_q != ARB_IDLE);
        done     = in_grant && (bus.ramstate == ACCESS);

        // Arbitration uses the post-completion count so the LIMIT-th dcache grant
        // hands the port to the icache on the very next cycle.
        cnt_d = cnt_q;
        if (!bus.iREN) begin
            cnt_d = '0;
        end else if (done && state_q == ARB_I) begin
            cnt_d = '0;
        end else if (done && state_q == ARB_D && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        err_d = err_q | (in_grant && bus.ramstate == ERROR);

        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: state_d = pick(cnt_d, d_req, i_ok);
            ARB_I: begin
                if (done)           state_d = pick(cnt_d, d_req, i_ok);
                else if (!bus.iREN) state_d = ARB_IDLE;
            end
            ARB_D: begin
                if (done)                        state_d = bus.dlock ? ARB_D : pick(cnt_d, d_req, i_ok);
                else if (!d_req && !bus.dlock)   state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.igrant   = (state_q == ARB_I);
        bus.dgrant   = (state_q == ARB_D);
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state_q)
            ARB_I: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
            end
            ARB_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
        bus.iwait   = ~((state_q == ARB_I) && (bus.ramstate == ACCESS));
        bus.dwait   = ~((state_q == ARB_D) && (bus.ramstate == ACCESS));
        bus.iload   = bus.ramload;
        bus.dload   = bus.ramload;
        bus.arb_err = err_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed + randomized bench for cache_mem_arbiter against a port-ownership model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the RAM port, how many dcache grants in a row
    // the waiting icache has suffered, and the sticky error flag.
    int   owner;
    int   streak;
    logic err_m;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int cnt, input logic dreq, input logic iok);
        if (iok && cnt >= STARVE_LIMIT) return OWN_I;
        if (dreq) return OWN_D;
        if (iok) return OWN_I;
        return OWN_NONE;
    endfunction

    task automatic check_all();
        logic  e_ren, e_wen;
        word_t e_addr, e_store;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        if (owner == OWN_I) begin
            e_ren  = bus.iREN;
            e_addr = bus.iaddr;
        end else if (owner == OWN_D) begin
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN & ~bus.dWEN;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
        end
        chk1 ("igrant",   bus.igrant, owner == OWN_I);
        chk1 ("dgrant",   bus.dgrant, owner == OWN_D);
        chk1 ("ramREN",   bus.ramREN, e_ren);
        chk1 ("ramWEN",   bus.ramWEN, e_wen);
        chk32("ramaddr",  bus.ramaddr, e_addr);
        chk32("ramstore", bus.ramstore, e_store);
        chk1 ("iwait",    bus.iwait, !(owner == OWN_I && bus.ramstate == ACCESS));
        chk1 ("dwait",    bus.dwait, !(owner == OWN_D && bus.ramstate == ACCESS));
        chk32("iload",    bus.iload, bus.ramload);
        chk32("dload",    bus.dload, bus.ramload);
        chk1 ("arb_err",  bus.arb_err, err_m);
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge.
    task automatic cyc();
        int   nxt;
        int   cnt_after;
        logic done;
        @(negedge CLK);
        #1;
        check_all();
        done = (owner != OWN_NONE) && (bus.ramstate == ACCESS);
        if (owner != OWN_NONE && bus.ramstate == ERROR) err_m = 1'b1;
        cnt_after = streak;
        if (!bus.iREN)                    cnt_after = 0;
        else if (done && owner == OWN_I)  cnt_after = 0;
        else if (done && owner == OWN_D)  cnt_after = (streak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : streak + 1;
        nxt = owner;
        if (owner == OWN_NONE) begin
            nxt = pick(cnt_after, bus.dREN | bus.dWEN, bus.iREN & ~bus.halt);
        end else if (done) begin
            if (owner == OWN_D && bus.dlock) nxt = OWN_D;
            else nxt = pick(cnt_after, bus.dREN | bus.dWEN, bus.iREN & ~bus.halt);
        end else if (owner == OWN_I && !bus.iREN) begin
            nxt = OWN_NONE;
        end else if (owner == OWN_D && !bus.dREN && !bus.dWEN && !bus.dlock) begin
            nxt = OWN_NONE;
        end
        @(posedge CLK);
        owner  = nxt;
        streak = cnt_after;
        #1;
    endtask

    task automatic apply_reset_mid();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        owner = OWN_NONE; streak = 0; err_m = 1'b0;
        check_all();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.halt = 1'b0; bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.dlock = 1'b0;
        bus.ramstate = FREE;
    endtask

    initial begin
        int r;
        RST = 1'b1;
        idle_inputs();
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
        owner = OWN_NONE; streak = 0; err_m = 1'b0;
        #1;
        check_all();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // icache read with two BUSY cycles
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramload = 32'h8C010004;
        cyc();
        bus.ramstate = BUSY;   cyc(); cyc();
        bus.ramstate = ACCESS; cyc();
        bus.iREN = 1'b0; bus.ramstate = FREE; cyc();

        // simultaneous requests: dcache first, then icache without a bubble
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100;
        cyc();
        bus.dREN = 1'b0; bus.ramstate = ACCESS; cyc();
        cyc();
        idle_inputs(); cyc();

        // locked two-word writeback while icache waits
        bus.iREN = 1'b1; bus.dWEN = 1'b1; bus.dlock = 1'b1;
        bus.daddr = 32'h200; bus.dstore = 32'hDEAD;
        cyc();
        bus.ramstate = BUSY;   cyc();
        bus.ramstate = ACCESS; cyc();
        bus.daddr = 32'h204; bus.dstore = 32'hBEEF; cyc();
        bus.dWEN = 1'b0; bus.dlock = 1'b0; bus.ramstate = FREE; cyc();
        cyc();
        bus.ramstate = ACCESS; cyc();
        idle_inputs(); cyc();

        // starvation: continuous dcache reads with icache pending
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ACCESS;
        for (int n = 0; n < 14; n++) cyc();
        idle_inputs(); cyc(); cyc();

        // halt holds off icache, dcache still served
        bus.halt = 1'b1; bus.iREN = 1'b1;
        cyc(); cyc(); cyc();
        bus.dREN = 1'b1; bus.daddr = 32'h380; cyc();
        bus.ramstate = ACCESS; cyc();
        bus.dREN = 1'b0; bus.ramstate = FREE; cyc();
        idle_inputs(); cyc();

        // RAM error is sticky; reset aborts a grant asynchronously
        bus.dREN = 1'b1; bus.daddr = 32'h3C0; cyc();
        bus.ramstate = ERROR;  cyc();
        bus.ramstate = BUSY;   cyc();
        bus.ramstate = ACCESS; cyc();
        bus.ramstate = BUSY;   cyc();
        apply_reset_mid();
        idle_inputs(); cyc();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.iREN    = ($urandom_range(0, 3) != 0);
            bus.dREN    = ($urandom_range(0, 1) == 1);
            bus.dWEN    = ($urandom_range(0, 3) == 0);
            bus.dlock   = ($urandom_range(0, 3) == 0);
            bus.halt    = ($urandom_range(0, 5) == 0);
            bus.iaddr   = $urandom;
            bus.daddr   = $urandom;
            bus.dstore  = $urandom;
            bus.ramload = $urandom;
            r = $urandom_range(0, 19);
            if (r < 8)       bus.ramstate = ACCESS;
            else if (r < 14) bus.ramstate = BUSY;
            else if (r < 19) bus.ramstate = FREE;
            else             bus.ramstate = ERROR;
            if (n == 150 || n == 300) apply_reset_mid();
            else cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
